// File: rtl/state_sequencer.sv
// state_sequencer: plays a programmed list of 8-bit states from an 8-entry
// pattern memory onto state_out, holding each one for (hold_sel+1) time units.
module state_sequencer #(
  parameter int unsigned CYCLES_PER_UNIT = 10000,
  parameter int unsigned PRE_W           = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] seq_len,
  input  logic [3:0] hold_sel,
  input  logic       loop,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] state_out,
  output logic       step_stb,
  output logic [2:0] step_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(CYCLES_PER_UNIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           fsm_q,   fsm_d;
  logic [PRE_W-1:0] pre_q,   pre_d;
  logic [3:0]       unit_q,  unit_d;
  logic [2:0]       len_q,   len_d;
  logic [3:0]       hsel_q,  hsel_d;
  logic             loop_q,  loop_d;
  logic [7:0]       out_q,   out_d;
  logic [2:0]       idx_q,   idx_d;
  logic             stb_q,   stb_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [7:0]       mem_q [8];
  logic             mem_we;
  logic             step_end;
  logic [2:0]       idx_nxt;

  assign step_end = (pre_q == '0) && (unit_q == '0);
  assign idx_nxt  = idx_q + 3'd1;

  always_comb begin
    fsm_d   = fsm_q;
    pre_d   = pre_q;
    unit_d  = unit_q;
    len_d   = len_q;
    hsel_d  = hsel_q;
    loop_d  = loop_q;
    out_d   = out_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    mem_we  = 1'b0;

    unique case (fsm_q)
      S_IDLE: begin
        busy_d = 1'b0;
        mem_we = wr_en;
        if (start && ena && !stop) begin
          len_d  = seq_len;
          hsel_d = hold_sel;
          loop_d = loop;
          idx_d  = '0;
          out_d  = mem_q[0];
          stb_d  = 1'b1;
          pre_d  = PRE_RELOAD;
          unit_d = hold_sel;
          busy_d = 1'b1;
          fsm_d  = S_HOLD;
        end
      end

      S_HOLD: begin
        // stop wins over a step end landing on the same edge
        if (stop) begin
          busy_d = 1'b0;
          fsm_d  = S_IDLE;
        end else if (ena) begin
          if (step_end) begin
            if (idx_q < len_q) begin
              idx_d  = idx_nxt;
              out_d  = mem_q[idx_nxt];
              stb_d  = 1'b1;
              pre_d  = PRE_RELOAD;
              unit_d = hsel_q;
            end else if (loop_q) begin
              idx_d  = '0;
              out_d  = mem_q[0];
              stb_d  = 1'b1;
              pre_d  = PRE_RELOAD;
              unit_d = hsel_q;
            end else begin
              busy_d = 1'b0;
              done_d = 1'b1;
              fsm_d  = S_DONE;
            end
          end else if (pre_q == '0) begin
            pre_d  = PRE_RELOAD;
            unit_d = unit_q - 4'd1;
          end else begin
            pre_d  = pre_q - 1'b1;
          end
        end
      end

      S_DONE: begin
        busy_d = 1'b0;
        fsm_d  = S_IDLE;
      end

      default: begin
        busy_d = 1'b0;
        fsm_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= S_IDLE;
      pre_q  <= '0;
      unit_q <= '0;
      len_q  <= '0;
      hsel_q <= '0;
      loop_q <= 1'b0;
      out_q  <= '0;
      idx_q  <= '0;
      stb_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      pre_q  <= pre_d;
      unit_q <= unit_d;
      len_q  <= len_d;
      hsel_q <= hsel_d;
      loop_q <= loop_d;
      out_q  <= out_d;
      idx_q  <= idx_d;
      stb_q  <= stb_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // pattern memory has no reset; writes only land while idle
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign state_out = out_q;
  assign step_stb  = stb_q;
  assign step_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
